// File: rtl/arbiter_rr_tracked.sv
// Round-robin arbiter with an in-order tracking FIFO. Grants are issued one per
// cycle while slots are free; the FIFO steers responses back to the granted manager.
module arbiter_rr_tracked #(
    parameter int NUM_M           = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int G_BITS          = $clog2(NUM_M + 1),
    parameter int C_BITS          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_M-1:0]  g_want,
    input  logic              req_accepted,
    input  logic              resp_accepted,
    output logic [G_BITS-1:0] g_req,
    output logic [G_BITS-1:0] g_resp,
    output logic [C_BITS-1:0] outstanding,
    output logic              full
);

    localparam int A_BITS = $clog2(MAX_OUTSTANDING);
    localparam logic [G_BITS-1:0] NONE    = G_BITS'(NUM_M);
    localparam logic [G_BITS-1:0] LAST    = G_BITS'(NUM_M - 1);
    localparam logic [G_BITS:0]   NUM_M_W = (G_BITS + 1)'(NUM_M);
    localparam logic [C_BITS-1:0] MAX_C   = C_BITS'(MAX_OUTSTANDING);

    logic [G_BITS-1:0] r_g_req;
    logic [G_BITS-1:0] r_rr_ptr;
    logic [G_BITS-1:0] r_fifo [MAX_OUTSTANDING];
    logic [A_BITS-1:0] r_wr_ptr;
    logic [A_BITS-1:0] r_rd_ptr;
    logic [C_BITS-1:0] r_count;

    logic              w_push;
    logic              w_pop;
    logic [C_BITS-1:0] w_count_next;
    logic [G_BITS-1:0] w_rr_next;
    logic              w_select;
    logic [2*NUM_M-1:0] w_want2;
    logic              w_found;
    logic [G_BITS-1:0] w_offset;
    logic [G_BITS:0]   w_sum;
    logic [G_BITS-1:0] w_winner;
    logic [G_BITS-1:0] w_g_req_next;

    assign w_push       = req_accepted && (r_g_req != NONE);
    assign w_pop        = resp_accepted && (r_count != '0);
    assign w_count_next = r_count + C_BITS'(w_push) - C_BITS'(w_pop);
    assign w_rr_next    = w_push ? ((r_g_req == LAST) ? '0 : r_g_req + G_BITS'(1)) : r_rr_ptr;
    assign w_select     = (r_g_req == NONE) || w_push;

    // Rotate requests so the updated RR pointer lands at bit 0, then take the first set bit.
    assign w_want2 = {g_want, g_want} >> w_rr_next;

    always_comb begin
        w_found  = 1'b0;
        w_offset = '0;
        for (int unsigned k = 0; k < NUM_M; k++) begin
            if (!w_found && w_want2[k]) begin
                w_found  = 1'b1;
                w_offset = G_BITS'(k);
            end
        end
    end

    assign w_sum    = {1'b0, w_rr_next} + {1'b0, w_offset};
    assign w_winner = (w_sum >= NUM_M_W) ? G_BITS'(w_sum - NUM_M_W) : G_BITS'(w_sum);

    always_comb begin
        w_g_req_next = r_g_req;
        if (w_select) begin
            w_g_req_next = (w_found && (w_count_next != MAX_C)) ? w_winner : NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_g_req  <= NONE;
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_g_req  <= w_g_req_next;
            r_rr_ptr <= w_rr_next;
            r_count  <= w_count_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + A_BITS'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + A_BITS'(1);
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= r_g_req;
    end

    assign g_req       = r_g_req;
    assign g_resp      = (r_count != '0) ? r_fifo[r_rd_ptr] : NONE;
    assign outstanding = r_count;
    assign full        = (r_count == MAX_C);

endmodule

// File: tb/tb_arbiter_rr_tracked.sv
// Directed bench for arbiter_rr_tracked with NUM_M=3, MAX_OUTSTANDING=4.
module tb_arbiter_rr_tracked;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] g_want;
    logic       req_accepted;
    logic       resp_accepted;
    logic [1:0] g_req;
    logic [1:0] g_resp;
    logic [2:0] outstanding;
    logic       full;

    int checks   = 0;
    int failures = 0;

    arbiter_rr_tracked #(
        .NUM_M(3),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .g_want(g_want),
        .req_accepted(req_accepted),
        .resp_accepted(resp_accepted),
        .g_req(g_req),
        .g_resp(g_resp),
        .outstanding(outstanding),
        .full(full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_req, input int e_resp,
                           input int e_out, input int e_full);
        chk({tag, ".g_req"}, 32'(g_req), e_req);
        chk({tag, ".g_resp"}, 32'(g_resp), e_resp);
        chk({tag, ".outstanding"}, 32'(outstanding), e_out);
        chk({tag, ".full"}, 32'(full), e_full);
    endtask

    initial begin
        rst = 1'b1; g_want = 3'b111; req_accepted = 1'b0; resp_accepted = 1'b0;
        tick(); tick();
        chk_all("reset", 3, 3, 0, 0);

        // Single transaction
        rst = 1'b0; g_want = 3'b000;
        tick();
        chk("idle.g_req", 32'(g_req), 3);
        g_want = 3'b001;
        tick();
        chk("single.grant", 32'(g_req), 0);
        g_want = 3'b000; req_accepted = 1'b1;
        tick();
        chk_all("single.accept", 3, 0, 1, 0);
        req_accepted = 1'b0; resp_accepted = 1'b1;
        tick();
        chk_all("single.resp", 3, 3, 0, 0);
        tick();
        chk("empty_pop_ignored.out", 32'(outstanding), 0);
        chk("empty_pop_ignored.g_resp", 32'(g_resp), 3);

        // Round-robin fill from a fresh RR pointer
        resp_accepted = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; g_want = 3'b111;
        tick();
        chk("rr.g0", 32'(g_req), 0);
        req_accepted = 1'b1;
        tick();
        chk("rr.g1", 32'(g_req), 1);
        chk("rr.out1", 32'(outstanding), 1);
        tick();
        chk("rr.g2", 32'(g_req), 2);
        tick();
        chk("rr.g3", 32'(g_req), 0);
        chk("rr.out3", 32'(outstanding), 3);
        tick();
        chk_all("rr.full", 3, 0, 4, 1);
        tick();
        chk_all("rr.accept_none_ignored", 3, 0, 4, 1);

        // Full release: pop frees a slot, RR pointer is 1
        req_accepted = 1'b0; resp_accepted = 1'b1;
        tick();
        chk_all("release", 1, 1, 3, 0);
        tick();
        chk_all("pop2", 1, 2, 2, 0);
        tick();
        chk_all("pop3", 1, 0, 1, 0);
        tick();
        chk_all("pop4", 1, 3, 0, 0);

        // Simultaneous push and pop
        resp_accepted = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; g_want = 3'b111;
        tick();
        req_accepted = 1'b1;
        tick(); tick();
        chk_all("pp.setup", 2, 0, 2, 0);
        resp_accepted = 1'b1;
        tick();
        chk_all("pp.both", 0, 1, 2, 0);
        req_accepted = 1'b0;
        tick();
        chk_all("pp.drain1", 0, 2, 1, 0);
        tick();
        chk_all("pp.drain2", 0, 3, 0, 0);

        // Sticky grant and mid-operation reset
        resp_accepted = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; g_want = 3'b001;
        tick();
        chk("sticky.g0", 32'(g_req), 0);
        g_want = 3'b010; req_accepted = 1'b1;
        tick();
        chk("sticky.g1", 32'(g_req), 1);
        g_want = 3'b000; req_accepted = 1'b0;
        tick();
        chk("sticky.hold1", 32'(g_req), 1);
        tick();
        chk("sticky.hold2", 32'(g_req), 1);
        req_accepted = 1'b1;
        tick();
        chk_all("sticky.two_out", 3, 0, 2, 0);
        req_accepted = 1'b0; rst = 1'b1;
        tick();
        chk_all("midreset", 3, 3, 0, 0);
        rst = 1'b0; g_want = 3'b110;
        tick();
        chk("midreset.rr_ptr0", 32'(g_req), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
